// File: rtl/bcd_pkg.sv
// Purpose: shared constants, FSM state encoding and digit helpers for the BCD datapath.
// Latency: none (declarations only).
// Backpressure: not applicable.
package bcd_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    COMP = 2'd2,
    DONE = 2'd3
  } state_e;

  // True when a 4-bit code is a legal decimal digit (0..9).
  function automatic logic bcd_digit_valid(input logic [BCD_W-1:0] d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Purpose: one decimal digit of x - y - bin with borrow-out; r is always 0..9 for legal inputs.
// Latency: purely combinational.
// Backpressure: none; the caller sequences digits.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] x,
  input  logic [BCD_W-1:0] y,
  input  logic             bin,
  output logic [BCD_W-1:0] r,
  output logic             bout
);

  localparam logic [BCD_W-1:0] TEN = BCD_W'(10);

  // One extra bit holds the sign: for legal digits t spans -10..9, so the
  // top bit of the wrapped difference is exactly the borrow.
  logic [BCD_W:0] t;

  // Binary difference, then add ten back when it went negative.
  always_comb begin
    t    = {1'b0, x} - {1'b0, y} - {{BCD_W{1'b0}}, bin};
    bout = t[BCD_W];
    r    = bout ? (t[BCD_W-1:0] + TEN) : t[BCD_W-1:0];
  end

endmodule

// File: rtl/bcd_sub_seq.sv
// Purpose: digit-serial |a - b| in packed BCD with sign and invalid-digit flags.
// Latency: done after start+DIGITS+1 edges (a>=b), +2*DIGITS+1 (a<b), +1 (invalid digit).
// Backpressure: start is only sampled in IDLE; results hold until the next accepted start.
module bcd_sub_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BCD_W*DIGITS-1:0] a,
  input  logic [BCD_W*DIGITS-1:0] b,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] diff,
  output logic                    neg,
  output logic                    invalid
);

  localparam int W     = BCD_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic             chk_q, chk_d;
  logic             neg_q, neg_d;
  logic             inv_q, inv_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     diff_q, diff_d;

  logic [BCD_W-1:0] a_dig, b_dig, diff_dig;
  logic [BCD_W-1:0] sub_x, sub_y, sub_r;
  logic             sub_bout;
  logic [W-1:0]     diff_wr;
  logic             ops_ok;

  // Select the current digit of each operand and of the running result.
  always_comb begin
    a_dig    = '0;
    b_dig    = '0;
    diff_dig = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_dig    = a_q[i*BCD_W +: BCD_W];
        b_dig    = b_q[i*BCD_W +: BCD_W];
        diff_dig = diff_q[i*BCD_W +: BCD_W];
      end
    end
  end

  // Check every captured digit; evaluated on the registered operands.
  always_comb begin
    ops_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_digit_valid(a_q[i*BCD_W +: BCD_W]) ||
          !bcd_digit_valid(b_q[i*BCD_W +: BCD_W])) begin
        ops_ok = 1'b0;
      end
    end
  end

  // COMP reuses the digit subtractor as 0 - diff_i - borrow.
  always_comb begin
    sub_x = (state_q == COMP) ? '0       : a_dig;
    sub_y = (state_q == COMP) ? diff_dig : b_dig;
  end

  bcd_digit_sub u_digit_sub (
    .x    (sub_x),
    .y    (sub_y),
    .bin  (borrow_q),
    .r    (sub_r),
    .bout (sub_bout)
  );

  // Running result with the current digit replaced by the subtractor output.
  always_comb begin
    diff_wr = diff_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        diff_wr[i*BCD_W +: BCD_W] = sub_r;
      end
    end
  end

  // Next-state and datapath updates for the IDLE/SUB/COMP/DONE sequence.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    chk_d    = chk_q;
    neg_d    = neg_q;
    inv_d    = inv_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          diff_d   = '0;
          neg_d    = 1'b0;
          inv_d    = 1'b0;
          borrow_d = 1'b0;
          idx_d    = '0;
          chk_d    = 1'b1;
          state_d  = SUB;
        end
      end

      SUB: begin
        if (chk_q) begin
          // First SUB cycle only validates the captured operands; digit
          // work starts on the following cycle.
          chk_d = 1'b0;
          if (!ops_ok) begin
            inv_d   = 1'b1;
            state_d = DONE;
          end
        end else begin
          diff_d   = diff_wr;
          borrow_d = sub_bout;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (sub_bout) begin
              // a < b: diff now holds the ten's complement of the magnitude.
              borrow_d = 1'b0;
              state_d  = COMP;
            end else begin
              state_d = DONE;
            end
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end

      COMP: begin
        diff_d   = diff_wr;
        borrow_d = sub_bout;
        if (idx_q == LAST_IDX) begin
          idx_d    = '0;
          borrow_d = 1'b0;
          neg_d    = 1'b1;
          state_d  = DONE;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      chk_q    <= 1'b0;
      neg_q    <= 1'b0;
      inv_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      chk_q    <= chk_d;
      neg_q    <= neg_d;
      inv_q    <= inv_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign diff    = diff_q;
  assign neg     = neg_q;
  assign invalid = inv_q;

endmodule

// File: tb/tb_bcd_sub_seq.sv
// Purpose: directed self-checking bench for bcd_sub_seq with DIGITS=4.
// Latency: expected done latencies are hand-derived per scenario.
// Backpressure: exercises ignored mid-operation start and held-high start.
module tb_bcd_sub_seq;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         neg;
  logic         invalid;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_sub_seq #(.DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .diff    (diff),
    .neg     (neg),
    .invalid (invalid)
  );

  always #5 clk = ~clk;

  // Issue one operation from IDLE (caller sits 1 time unit after an edge)
  // and report latency in edges after capture (-1 on timeout).
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       output int lat, output logic [W-1:0] d,
                       output logic n, output logic inv,
                       output logic done_next);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    d   = diff;
    n   = neg;
    inv = invalid;
    @(posedge clk); #1;
    done_next = done;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #23;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (diff !== 16'h0000) begin n_bad++; $display("FAIL reset_diff: got %h want 0000", diff); end
    n_cmp++; if ({neg, invalid} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got %b want 00", {neg, invalid}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_positive;
    int lat; logic [W-1:0] d; logic n, inv, dn;
    do_op(16'h5321, 16'h1234, lat, d, n, inv, dn);
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL pos_latency: got %0d want 5", lat); end
    n_cmp++; if (d !== 16'h4087) begin n_bad++; $display("FAIL pos_diff: got %h want 4087", d); end
    n_cmp++; if ({n, inv} !== 2'b00) begin n_bad++; $display("FAIL pos_flags: got %b want 00", {n, inv}); end
    n_cmp++; if (dn !== 1'b0) begin n_bad++; $display("FAIL pos_done_pulse: got %b want 0", dn); end
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++; if (diff !== 16'h4087) begin n_bad++; $display("FAIL pos_hold_diff: got %h want 4087", diff); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL pos_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_negative;
    int lat; logic [W-1:0] d; logic n, inv, dn;
    do_op(16'h1234, 16'h5321, lat, d, n, inv, dn);
    n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL neg_latency: got %0d want 9", lat); end
    n_cmp++; if (d !== 16'h4087) begin n_bad++; $display("FAIL neg_diff: got %h want 4087", d); end
    n_cmp++; if ({n, inv} !== 2'b10) begin n_bad++; $display("FAIL neg_flags: got %b want 10", {n, inv}); end
  endtask

  task automatic test_borrow_chain;
    int lat; logic [W-1:0] d; logic n, inv, dn;
    do_op(16'h0500, 16'h0499, lat, d, n, inv, dn);
    n_cmp++; if ({lat == 5, d, n} !== {1'b1, 16'h0001, 1'b0}) begin n_bad++; $display("FAIL chain_0500_0499: got lat=%0d diff=%h neg=%b want lat=5 diff=0001 neg=0", lat, d, n); end
    do_op(16'h0000, 16'h9999, lat, d, n, inv, dn);
    n_cmp++; if ({lat == 9, d, n} !== {1'b1, 16'h9999, 1'b1}) begin n_bad++; $display("FAIL chain_0000_9999: got lat=%0d diff=%h neg=%b want lat=9 diff=9999 neg=1", lat, d, n); end
    do_op(16'h7777, 16'h7777, lat, d, n, inv, dn);
    n_cmp++; if ({lat == 5, d, n} !== {1'b1, 16'h0000, 1'b0}) begin n_bad++; $display("FAIL equal_7777: got lat=%0d diff=%h neg=%b want lat=5 diff=0000 neg=0", lat, d, n); end
  endtask

  task automatic test_invalid;
    int lat; logic [W-1:0] d; logic n, inv, dn;
    do_op(16'h00A0, 16'h0001, lat, d, n, inv, dn);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL inv_latency: got %0d want 1", lat); end
    n_cmp++; if ({inv, n, d} !== {1'b1, 1'b0, 16'h0000}) begin n_bad++; $display("FAIL inv_a_result: got inv=%b neg=%b diff=%h want inv=1 neg=0 diff=0000", inv, n, d); end
    do_op(16'h0010, 16'h0001, lat, d, n, inv, dn);
    n_cmp++; if ({lat == 5, inv, n, d} !== {1'b1, 1'b0, 1'b0, 16'h0009}) begin n_bad++; $display("FAIL inv_cleared: got lat=%0d inv=%b neg=%b diff=%h want lat=5 inv=0 neg=0 diff=0009", lat, inv, n, d); end
    do_op(16'h0001, 16'hF000, lat, d, n, inv, dn);
    n_cmp++; if ({lat == 1, inv, d} !== {1'b1, 1'b1, 16'h0000}) begin n_bad++; $display("FAIL inv_b_result: got lat=%0d inv=%b diff=%h want lat=1 inv=1 diff=0000", lat, inv, d); end
  endtask

  task automatic test_ignore_start;
    int lat;
    a = 16'h5321;
    b = 16'h1234;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'h9999;
    b = 16'h0000;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ign_busy_rise: got %b want 1", busy); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 4; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    n_cmp++; if ({lat == 5, diff, neg} !== {1'b1, 16'h4087, 1'b0}) begin n_bad++; $display("FAIL ign_result: got lat=%0d diff=%h neg=%b want lat=5 diff=4087 neg=0", lat, diff, neg); end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ign_no_restart: got busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    int lat;
    a = 16'h5321;
    b = 16'h1234;
    start = 1'b1;
    @(posedge clk); #1;
    a = 16'h2222;
    b = 16'h3333;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    n_cmp++; if ({lat == 5, diff, neg} !== {1'b1, 16'h4087, 1'b0}) begin n_bad++; $display("FAIL b2b_first: got lat=%0d diff=%h neg=%b want lat=5 diff=4087 neg=0", lat, diff, neg); end
    @(posedge clk); #1;
    n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL b2b_idle_gap: got busy,done=%b want 00", {busy, done}); end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept: got busy=%b want 1", busy); end
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    n_cmp++; if ({lat == 9, diff, neg} !== {1'b1, 16'h1111, 1'b1}) begin n_bad++; $display("FAIL b2b_second: got lat=%0d diff=%h neg=%b want lat=9 diff=1111 neg=1", lat, diff, neg); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int lat; logic [W-1:0] d; logic n, inv, dn;
    logic saw_done;
    a = 16'h1234;
    b = 16'h5321;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, done, neg, invalid, diff} !== {4'b0000, 16'h0000}) begin n_bad++; $display("FAIL mid_reset_outputs: got busy=%b done=%b neg=%b inv=%b diff=%h want all 0", busy, done, neg, invalid, diff); end
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    n_cmp++; if (saw_done !== 1'b0) begin n_bad++; $display("FAIL mid_no_done: got %b want 0", saw_done); end
    do_op(16'h5321, 16'h1234, lat, d, n, inv, dn);
    n_cmp++; if ({lat == 5, d, n} !== {1'b1, 16'h4087, 1'b0}) begin n_bad++; $display("FAIL mid_recover: got lat=%0d diff=%h neg=%b want lat=5 diff=4087 neg=0", lat, d, n); end
  endtask

  initial begin
    test_reset();
    test_positive();
    test_negative();
    test_borrow_chain();
    test_invalid();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
